// File: rtl/ofmap_bit_packer.sv
// Packs single activation bits LSB-first into WORD_WIDTH-bit ofmap BRAM words.
// Define OFMAP_WMASK_EN to add the per-bit bram_wmask output for partial-word writes.
module ofmap_bit_packer #(
    parameter int OFMAPS_BRAM_ADDR_WIDTH = 12,
    parameter int WORD_WIDTH             = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_data,
    input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] i_addr,
    input  logic                              i_valid,
    input  logic                              i_flush,
    output logic                              bram_we,
    output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [WORD_WIDTH-1:0]             bram_wdata,
`ifdef OFMAP_WMASK_EN
    output logic [WORD_WIDTH-1:0]             bram_wmask,
`endif
    output logic [OFMAPS_BRAM_ADDR_WIDTH:0]   words_written,
    output logic                              o_idle
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FILL  = 1'b1;

    logic [0:0]                        state, state_nx;
    logic [CNT_W-1:0]                  cnt, cnt_nx;
    logic [WORD_WIDTH-1:0]             pack_buf, buf_nx;
    logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] cur_addr, addr_nx;
    logic                              flush_pend, pend_nx;
    logic                              same_addr, last_bit;
    logic                              wr;
    logic [WORD_WIDTH-1:0]             wr_data, bit_in;

    assign same_addr = (i_addr == cur_addr);
    assign last_bit  = (cnt == CNT_W'(WORD_WIDTH - 1));
    assign bit_in    = WORD_WIDTH'(i_data) << cnt;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        buf_nx   = pack_buf;
        addr_nx  = cur_addr;
        pend_nx  = flush_pend;
        wr       = 1'b0;
        wr_data  = pack_buf;
        if (i_valid) begin
            // A flush arriving with a beat waits for the first idle input cycle.
            if (i_flush)
                pend_nx = 1'b1;
            if (state == ST_EMPTY || !same_addr) begin
                wr       = (state == ST_FILL);
                buf_nx   = WORD_WIDTH'(i_data);
                cnt_nx   = CNT_W'(1);
                addr_nx  = i_addr;
                state_nx = ST_FILL;
            end else if (last_bit) begin
                wr       = 1'b1;
                wr_data  = pack_buf | bit_in;
                buf_nx   = '0;
                cnt_nx   = '0;
                state_nx = ST_EMPTY;
            end else begin
                buf_nx = pack_buf | bit_in;
                cnt_nx = cnt + CNT_W'(1);
            end
        end else if (i_flush || flush_pend) begin
            pend_nx  = 1'b0;
            wr       = (state == ST_FILL);
            buf_nx   = '0;
            cnt_nx   = '0;
            state_nx = ST_EMPTY;
        end
    end

`ifdef OFMAP_WMASK_EN
    function automatic logic [WORD_WIDTH-1:0] lsb_mask(input logic [CNT_W-1:0] n);
        logic [WORD_WIDTH-1:0] m;
        for (int i = 0; i < WORD_WIDTH; i++)
            m[i] = (i < int'(n));
        return m;
    endfunction

    logic [WORD_WIDTH-1:0] wr_mask;
    assign wr_mask = (i_valid && state == ST_FILL && same_addr && last_bit) ? '1 : lsb_mask(cnt);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_EMPTY;
            cnt           <= '0;
            pack_buf      <= '0;
            cur_addr      <= '0;
            flush_pend    <= 1'b0;
            bram_we       <= 1'b0;
            bram_addr     <= '0;
            bram_wdata    <= '0;
`ifdef OFMAP_WMASK_EN
            bram_wmask    <= '0;
`endif
            words_written <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            pack_buf   <= buf_nx;
            cur_addr   <= addr_nx;
            flush_pend <= pend_nx;
            bram_we    <= wr;
            // Write port holds its last address/data between strobes.
            if (wr) begin
                bram_addr     <= cur_addr;
                bram_wdata    <= wr_data;
`ifdef OFMAP_WMASK_EN
                bram_wmask    <= wr_mask;
`endif
                words_written <= words_written + 1'b1;
            end
        end
    end

    assign o_idle = (state == ST_EMPTY) && !flush_pend && !bram_we;

endmodule

// File: tb/tb_ofmap_bit_packer.sv
// Directed and randomized bench for ofmap_bit_packer against a bit-queue reference model.
module tb_ofmap_bit_packer;

    localparam int AW = 12;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_data;
    logic [AW-1:0] i_addr;
    logic          i_valid;
    logic          i_flush;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [W-1:0]  bram_wdata;
`ifdef OFMAP_WMASK_EN
    logic [W-1:0]  bram_wmask;
`endif
    logic [AW:0]   words_written;
    logic          o_idle;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ofmap_bit_packer #(.OFMAPS_BRAM_ADDR_WIDTH(AW), .WORD_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .i_data(i_data),
        .i_addr(i_addr),
        .i_valid(i_valid),
        .i_flush(i_flush),
        .bram_we(bram_we),
        .bram_addr(bram_addr),
        .bram_wdata(bram_wdata),
`ifdef OFMAP_WMASK_EN
        .bram_wmask(bram_wmask),
`endif
        .words_written(words_written),
        .o_idle(o_idle)
    );

    // Reference model: buffered bits as a queue, expected write port contents.
    bit          m_bits[$];
    logic [AW-1:0] m_addr;
    bit          m_pend;
    bit          m_we;
    logic [AW-1:0] m_waddr;
    logic [W-1:0]  m_wdata;
    logic [W-1:0]  m_wmask;
    logic [AW:0]   m_wcnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_addr  = '0;
        m_pend  = 1'b0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_wmask = '0;
        m_wcnt  = '0;
    endtask

    task automatic emit();
        m_we    = 1'b1;
        m_waddr = m_addr;
        m_wdata = '0;
        m_wmask = '0;
        foreach (m_bits[i]) begin
            m_wdata[i] = m_bits[i];
            m_wmask[i] = 1'b1;
        end
        m_wcnt = m_wcnt + 1'b1;
        m_bits.delete();
    endtask

    task automatic model_step(input logic v, input logic d, input logic [AW-1:0] a, input logic f);
        m_we = 1'b0;
        if (v) begin
            if (m_bits.size() != 0 && a != m_addr)
                emit();
            if (m_bits.size() == 0)
                m_addr = a;
            m_bits.push_back(d);
            if (m_bits.size() == W)
                emit();
            if (f)
                m_pend = 1'b1;
        end else if (f || m_pend) begin
            if (m_bits.size() != 0)
                emit();
            m_pend = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("we", 64'(bram_we), 64'(m_we));
        chk("addr", 64'(bram_addr), 64'(m_waddr));
        chk("wdata", 64'(bram_wdata), 64'(m_wdata));
`ifdef OFMAP_WMASK_EN
        chk("wmask", 64'(bram_wmask), 64'(m_wmask));
`endif
        chk("count", 64'(words_written), 64'(m_wcnt));
        chk("idle", 64'(o_idle), 64'((m_bits.size() == 0) && !m_pend && !m_we));
    endtask

    task automatic step(input logic v, input logic d, input logic [AW-1:0] a, input logic f);
        @(negedge clk);
        rst     = 1'b0;
        i_valid = v;
        i_data  = d;
        i_addr  = a;
        i_flush = f;
        model_step(v, d, a, f);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = 1'b1;
        i_addr  = AW'($urandom);
        i_flush = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] ra;
        rst = 1'b1; i_valid = 1'b0; i_data = 1'b0; i_addr = '0; i_flush = 1'b0;
        model_reset();

        // Reset state and flush while empty
        do_reset();
        chk("rst_idle", 64'(o_idle), 64'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("r036_we", 64'(bram_we), 64'd0);
        chk("r036_idle", 64'(o_idle), 64'd1);

        // Full alternating word at address 5
        do_reset();
        for (int i = 0; i < 32; i++)
            step(1'b1, (i % 2) == 0, AW'(5), 1'b0);
        chk("r031_we", 64'(bram_we), 64'd1);
        chk("r031_addr", 64'(bram_addr), 64'd5);
        chk("r031_data", 64'(bram_wdata), 64'h55555555);
        chk("r031_count", 64'(words_written), 64'd1);
`ifdef OFMAP_WMASK_EN
        chk("r031_mask", 64'(bram_wmask), 64'hFFFFFFFF);
`endif
        step(1'b0, 1'b0, '0, 1'b0);
        chk("r031_we_drop", 64'(bram_we), 64'd0);

        // Address change then flush
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, AW'(7), 1'b0);
        step(1'b1, 1'b1, AW'(8), 1'b0);
        chk("r032_addr7", 64'(bram_addr), 64'd7);
        chk("r032_data7", 64'(bram_wdata), 64'h7);
`ifdef OFMAP_WMASK_EN
        chk("r032_mask7", 64'(bram_wmask), 64'h7);
`endif
        step(1'b0, 1'b0, '0, 1'b1);
        chk("r032_addr8", 64'(bram_addr), 64'd8);
        chk("r032_data8", 64'(bram_wdata), 64'h1);
`ifdef OFMAP_WMASK_EN
        chk("r032_mask8", 64'(bram_wmask), 64'h1);
`endif

        // Flush coincident with a beat becomes pending
        step(1'b1, 1'b1, AW'(9), 1'b0);
        step(1'b1, 1'b1, AW'(9), 1'b1);
        chk("r033_no_we", 64'(bram_we), 64'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("r033_we", 64'(bram_we), 64'd1);
        chk("r033_addr", 64'(bram_addr), 64'd9);
        chk("r033_data", 64'(bram_wdata), 64'h3);
        step(1'b0, 1'b0, '0, 1'b0);

        // Reset mid-word discards buffered bits
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'($urandom_range(1, 0)), AW'(3), 1'b0);
        do_reset();
        chk("r034_count", 64'(words_written), 64'd0);
        chk("r034_idle", 64'(o_idle), 64'd1);
        for (int i = 0; i < 32; i++)
            step(1'b1, 1'($urandom_range(1, 0)), AW'(3), 1'b0);
        chk("r034_full_we", 64'(bram_we), 64'd1);
        chk("r034_full_addr", 64'(bram_addr), 64'd3);

        // Back-to-back full words over 64 addresses
        do_reset();
        for (int a = 0; a < 64; a++)
            for (int b = 0; b < 32; b++)
                step(1'b1, 1'($urandom_range(1, 0)), AW'(a), 1'b0);
        chk("r035_count", 64'(words_written), 64'd64);

        // Randomized traffic
        do_reset();
        ra = AW'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39, 0) == 0)
                ra = AW'($urandom);
            step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), ra,
                 1'($urandom_range(9, 0) == 0));
        end
        step(1'b0, 1'b0, '0, 1'b1);

        // Write counter wraps modulo 2^(AW+1)
        do_reset();
        for (int i = 0; i < 8200; i++)
            step(1'b1, 1'($urandom_range(1, 0)), AW'(i % 2), 1'b0);
        chk("wrap_count", 64'(words_written), 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ofmap_bit_packer.md
OFMAP_BIT_PACKER -- requirements
Module: ofmap_bit_packer

Interface
REQ-001 SHALL have parameter OFMAPS_BRAM_ADDR_WIDTH, default 12, the ofmaps BRAM word-address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, the BRAM data width in bits; legal values are powers of two from 2 to 64.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_data  input  1  binary activation bit from the psum adder/threshold stage.
REQ-006 i_addr  input  OFMAPS_BRAM_ADDR_WIDTH  target BRAM word address of i_data.
REQ-007 i_valid  input  1  i_data/i_addr qualifier; no backpressure, so every valid beat SHALL be accepted.
REQ-008 i_flush  input  1  force write-out of any partially filled word.
REQ-009 bram_we  output  1  one-cycle write strobe.
REQ-010 bram_addr  output  OFMAPS_BRAM_ADDR_WIDTH  write word address.
REQ-011 bram_wdata  output  WORD_WIDTH  packed write data.
REQ-012 bram_wmask  output  WORD_WIDTH  per-bit write enable; present only when OFMAP_WMASK_EN is defined.
REQ-013 words_written  output  OFMAPS_BRAM_ADDR_WIDTH+1  count of bram_we pulses since reset.
REQ-014 o_idle  output  1  high when no bits are buffered, no flush is pending and bram_we is low.

Function
REQ-015 SHALL hold a WORD_WIDTH-bit packing buffer, a bit counter cnt (0..WORD_WIDTH), a current address cur_addr, and a two-state FSM: EMPTY and FILL.
REQ-016 EMPTY + i_valid: buffer bit 0 = i_data, all other buffer bits = 0, cnt = 1, cur_addr = i_addr, go to FILL.
REQ-017 FILL + i_valid + i_addr == cur_addr: write i_data at buffer bit cnt and increment cnt; packing order SHALL be LSB-first.
REQ-018 When REQ-017 makes cnt reach WORD_WIDTH, the full word SHALL be written at cur_addr and the FSM SHALL go to EMPTY.
REQ-019 FILL + i_valid + i_addr != cur_addr: the partial word SHALL be written at the old cur_addr and a new buffer SHALL be started from the incoming bit per REQ-016, staying in FILL, with no lost beat.
REQ-020 FILL + i_flush + !i_valid: the partial word SHALL be written and the FSM SHALL go to EMPTY.
REQ-021 EMPTY + i_flush + !i_valid: no write SHALL occur.
REQ-022 i_flush + i_valid in the same cycle: the beat SHALL be accepted per REQ-016..019 and the flush SHALL become pending; the pending flush SHALL execute on the first later cycle with i_valid low.
REQ-023 bram_we, bram_addr, bram_wdata and bram_wmask SHALL be registered; bram_we SHALL assert exactly one cycle after the triggering edge; at most one write per cycle.
REQ-024 Unfilled bits of a partial word SHALL be 0 in bram_wdata.
REQ-025 words_written SHALL increment on each bram_we and wrap modulo 2^(OFMAPS_BRAM_ADDR_WIDTH+1).
REQ-026 bram_addr/bram_wdata SHALL hold their last values while bram_we is low.

Reset
REQ-027 With rst high at a clock edge, all of the following SHALL be 0: bram_we, bram_addr, bram_wdata, bram_wmask, words_written, cnt, buffer and pending flush; the FSM SHALL go to EMPTY and o_idle SHALL be 1 on the following cycle.
REQ-028 Reset mid-word SHALL discard buffered bits without issuing a write; an i_valid beat sampled in the same cycle as rst SHALL be ignored.

Configuration
REQ-029 Macro OFMAP_WMASK_EN defined: bram_wmask SHALL exist and have bits 0..cnt-1 set for each write (all ones for a full word), so a partial write preserves the other BRAM bits.
REQ-030 Macro OFMAP_WMASK_EN undefined: there SHALL be no bram_wmask port, and every write, including a partial one, SHALL overwrite the whole word with zero padding.

Verification (WORD_WIDTH=32)
REQ-031 Reset, then 32 valid beats at addr 5 with bits alternating 1,0,1,0,... -> one bram_we the cycle after beat 32, addr 5, wdata 0x55555555, words_written 1, mask 0xFFFFFFFF.
REQ-032 3 beats of 1 at addr 7, then a beat of 1 at addr 8, then i_flush -> write addr 7 data 0x00000007 mask 0x00000007, then write addr 8 data 0x00000001 mask 0x00000001.
REQ-033 i_flush together with the 2nd beat at addr 9 (bits 1,1), then i_valid low -> single write addr 9 data 0x00000003 one cycle after the valid-low cycle.
REQ-034 rst pulsed after 10 beats at addr 3 -> no bram_we, words_written 0, o_idle 1; the next 32 beats at addr 3 produce a clean full word.
REQ-035 Continuous valid beats over 64 consecutive addresses, 32 beats each -> 64 writes in back-to-back-capable order, words_written 64, no dropped beats.
REQ-036 i_flush in EMPTY -> no write; o_idle stays 1.
